// File: rtl/core_logic_tbl.sv
// Rule-table driven state machine: (state, masked symbol) -> next state, lowest index wins.
// Adds direct-load, hit/miss status, last-fired rule index and a saturating hit counter.
module core_logic_tbl #(
    parameter int unsigned SW     = 4,
    parameter int unsigned IW     = 4,
    parameter int unsigned NRULES = 16,
    parameter int unsigned CNTW   = 16,
    localparam int unsigned AW    = $clog2(NRULES),
    localparam int unsigned DW    = 1 + 2*SW + 2*IW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [IW:0]     X,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    input  logic            cnt_clr,
    output logic [SW-1:0]   Y,
    output logic            hit,
    output logic            miss,
    output logic [AW-1:0]   rule_idx,
    output logic [CNTW-1:0] trans_cnt
);

    logic          rule_valid [NRULES];
    logic [SW-1:0] rule_cur   [NRULES];
    logic [IW-1:0] rule_mask  [NRULES];
    logic [IW-1:0] rule_val   [NRULES];
    logic [SW-1:0] rule_next  [NRULES];

    logic [IW-1:0] sym;
    logic [SW-1:0] load_val;
    logic          addr_ok;
    logic          match_found;
    logic [AW-1:0] match_idx;
    logic [SW-1:0] match_next;

    assign sym     = X[IW:1];
    assign addr_ok = (32'(cfg_addr) < NRULES);

    if (IW >= SW) begin : g_load_trunc
        assign load_val = sym[SW-1:0];
    end else begin : g_load_zext
        assign load_val = {{(SW-IW){1'b0}}, sym};
    end

    // Only the valid bits need reset; the payload is don't-care until a rule is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NRULES; i++) begin
                rule_valid[i] <= 1'b0;
            end
        end else if (cfg_we && addr_ok) begin
            rule_valid[cfg_addr] <= cfg_data[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && addr_ok) begin
            rule_cur[cfg_addr]  <= cfg_data[2*SW+2*IW-1 : SW+2*IW];
            rule_mask[cfg_addr] <= cfg_data[SW+2*IW-1 : SW+IW];
            rule_val[cfg_addr]  <= cfg_data[SW+IW-1 : SW];
            rule_next[cfg_addr] <= cfg_data[SW-1:0];
        end
    end

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        match_next  = '0;
        for (int unsigned i = 0; i < NRULES; i++) begin
            if (!match_found && rule_valid[i] && (rule_cur[i] == Y) &&
                ((sym & rule_mask[i]) == (rule_val[i] & rule_mask[i]))) begin
                match_found = 1'b1;
                match_idx   = AW'(i);
                match_next  = rule_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y         <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            rule_idx  <= '0;
            trans_cnt <= '0;
        end else begin
            if (!enable) begin
                Y    <= '0;
                hit  <= 1'b0;
                miss <= 1'b0;
            end else if (X[0]) begin
                Y    <= load_val;
                hit  <= 1'b0;
                miss <= 1'b0;
            end else if (match_found) begin
                Y        <= match_next;
                hit      <= 1'b1;
                miss     <= 1'b0;
                rule_idx <= match_idx;
                if (trans_cnt != '1) begin
                    trans_cnt <= trans_cnt + CNTW'(1);
                end
            end else begin
                hit  <= 1'b0;
                miss <= 1'b1;
            end
            // Clear overrides any increment scheduled above.
            if (cnt_clr) begin
                trans_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_core_logic_tbl.sv
// Self-checking bench for core_logic_tbl: directed scenarios plus randomized traffic
// compared against a rule-list reference model.
module tb_core_logic_tbl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  X = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [16:0] cfg_data = '0;
    logic        cnt_clr = 1'b0;
    logic [3:0]  Y;
    logic        hit;
    logic        miss;
    logic [3:0]  rule_idx;
    logic [1:0]  trans_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int m_y, m_hit, m_miss, m_idx, m_cnt;
    int m_valid [16];
    int m_cur   [16];
    int m_mask  [16];
    int m_val   [16];
    int m_next  [16];

    core_logic_tbl #(.SW(4), .IW(4), .NRULES(16), .CNTW(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .X(X),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cnt_clr(cnt_clr),
        .Y(Y), .hit(hit), .miss(miss), .rule_idx(rule_idx), .trans_cnt(trans_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_y = 0; m_hit = 0; m_miss = 0; m_idx = 0; m_cnt = 0;
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    // Advance one clock edge, updating the reference model from the inputs seen at that edge.
    task automatic tick();
        int sym;
        int found;
        sym = int'(X[4:1]);
        found = -1;
        if (!enable) begin
            m_y = 0; m_hit = 0; m_miss = 0;
        end else if (X[0]) begin
            m_y = sym; m_hit = 0; m_miss = 0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (found < 0 && m_valid[i] != 0 && m_cur[i] == m_y &&
                    (sym & m_mask[i]) == (m_val[i] & m_mask[i]))
                    found = i;
            end
            if (found >= 0) begin
                m_y = m_next[found]; m_hit = 1; m_miss = 0; m_idx = found;
                if (m_cnt < 3) m_cnt = m_cnt + 1;
            end else begin
                m_hit = 0; m_miss = 1;
            end
        end
        if (cnt_clr) m_cnt = 0;
        if (cfg_we) begin
            m_valid[cfg_addr] = int'(cfg_data[16]);
            m_cur[cfg_addr]   = int'(cfg_data[15:12]);
            m_mask[cfg_addr]  = int'(cfg_data[11:8]);
            m_val[cfg_addr]   = int'(cfg_data[7:4]);
            m_next[cfg_addr]  = int'(cfg_data[3:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int we, input int a, input int v, input int c,
                           input int m, input int val, input int n);
        cfg_we   = we[0];
        cfg_addr = a[3:0];
        cfg_data = {v[0], c[3:0], m[3:0], val[3:0], n[3:0]};
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({Y, hit, miss, rule_idx, trans_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_async: Y=%0d hit=%0d miss=%0d idx=%0d cnt=%0d want all 0",
                     Y, hit, miss, rule_idx, trans_cnt);
        end
        #1 rst_n = 1'b1;
        enable = 1'b1;
        X = 5'b10000;
        tick();
        n_tests++;
        if (miss !== 1'b1 || Y !== 4'd0 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_eval: Y=%0d hit=%0d miss=%0d want Y=0 hit=0 miss=1", Y, hit, miss);
        end
    endtask

    task automatic test_basic();
        X = 5'b00001;
        set_cfg(1, 0, 1, 0, 15, 8, 6); tick();
        set_cfg(1, 1, 1, 6, 15, 1, 1); tick();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        X = {4'b1000, 1'b0}; tick();
        n_tests++;
        if (Y !== 4'd6 || rule_idx !== 4'd0 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_step1: Y=%0d idx=%0d hit=%0d want Y=6 idx=0 hit=1", Y, rule_idx, hit);
        end
        X = {4'b0001, 1'b0}; tick();
        n_tests++;
        if (Y !== 4'd1 || rule_idx !== 4'd1 || trans_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL basic_step2: Y=%0d idx=%0d cnt=%0d want Y=1 idx=1 cnt=2", Y, rule_idx, trans_cnt);
        end
    endtask

    task automatic test_mask_priority();
        X = 5'b00001;
        set_cfg(1, 2, 1, 7, 13, 12, 2); tick();
        set_cfg(1, 3, 1, 7, 0, 0, 5); tick();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        X = 5'b01111; tick();
        n_tests++;
        if (Y !== 4'd7 || hit !== 1'b0 || miss !== 1'b0 || trans_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL load_7: Y=%0d hit=%0d miss=%0d cnt=%0d want Y=7 hit=0 miss=0 cnt=2",
                     Y, hit, miss, trans_cnt);
        end
        X = {4'b1110, 1'b0}; tick();
        n_tests++;
        if (Y !== 4'd2 || rule_idx !== 4'd2 || trans_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL masked_match: Y=%0d idx=%0d cnt=%0d want Y=2 idx=2 cnt=3", Y, rule_idx, trans_cnt);
        end
        X = 5'b01111; tick();
        X = {4'b0011, 1'b0}; tick();
        n_tests++;
        if (Y !== 4'd5 || rule_idx !== 4'd3 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL wildcard_rule: Y=%0d idx=%0d hit=%0d want Y=5 idx=3 hit=1", Y, rule_idx, hit);
        end
    endtask

    task automatic test_write_race();
        X = 5'b00001; tick();
        set_cfg(1, 0, 0, 0, 15, 8, 6);
        X = {4'b1000, 1'b0}; tick();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (Y !== 4'd6 || rule_idx !== 4'd0 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL race_old_rule: Y=%0d idx=%0d hit=%0d want Y=6 idx=0 hit=1", Y, rule_idx, hit);
        end
        X = 5'b00001; tick();
        X = {4'b1000, 1'b0}; tick();
        n_tests++;
        if (Y !== 4'd0 || miss !== 1'b1 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL race_removed: Y=%0d hit=%0d miss=%0d want Y=0 hit=0 miss=1", Y, hit, miss);
        end
    endtask

    task automatic test_counter();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        cnt_clr = 1'b1; X = 5'b00001; tick();
        cnt_clr = 1'b0;
        n_tests++;
        if (trans_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_clear: cnt=%0d want 0", trans_cnt);
        end
        set_cfg(1, 4, 1, 9, 0, 0, 9);
        X = {4'd9, 1'b1}; tick();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            X = {4'($urandom_range(0, 15)), 1'b0}; tick();
            n_tests++;
            if (trans_cnt !== 2'(exp_cnt[k]) || Y !== 4'd9 || rule_idx !== 4'd4) begin
                n_fail++;
                $display("FAIL cnt_sat_%0d: cnt=%0d Y=%0d idx=%0d want cnt=%0d Y=9 idx=4",
                         k, trans_cnt, Y, rule_idx, exp_cnt[k]);
            end
        end
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        n_tests++;
        if (trans_cnt !== 2'd0 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_clr_vs_hit: cnt=%0d hit=%0d want cnt=0 hit=1", trans_cnt, hit);
        end
    endtask

    task automatic test_enable();
        X = {4'd9, 1'b0}; tick();
        X = {4'd6, 1'b1}; tick();
        enable = 1'b0;
        set_cfg(1, 5, 1, 0, 0, 0, 3);
        X = {4'b1000, 1'b0}; tick();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        n_tests++;
        if (Y !== 4'd0 || hit !== 1'b0 || miss !== 1'b0 || rule_idx !== 4'd4 || trans_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL enable_clear: Y=%0d hit=%0d miss=%0d idx=%0d cnt=%0d want 0 0 0 4 1",
                     Y, hit, miss, rule_idx, trans_cnt);
        end
        X = {4'b0101, 1'b0}; tick();
        n_tests++;
        if (Y !== 4'd3 || rule_idx !== 4'd5 || trans_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL enable_cfg_kept: Y=%0d idx=%0d cnt=%0d want Y=3 idx=5 cnt=2", Y, rule_idx, trans_cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            enable  = ($urandom_range(0, 15) != 0);
            cnt_clr = enable && ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                X = {4'($urandom_range(0, 3)), 1'b1};
            else
                X = {4'($urandom_range(0, 15)), 1'b0};
            if ($urandom_range(0, 4) == 0)
                set_cfg(1, $urandom_range(0, 15), ($urandom_range(0, 4) != 0),
                        $urandom_range(0, 3), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 3));
            else
                set_cfg(0, 0, 0, 0, 0, 0, 0);
            tick();
            n_tests++;
            if ({Y, hit, miss, rule_idx, trans_cnt} !==
                {4'(m_y), 1'(m_hit), 1'(m_miss), 4'(m_idx), 2'(m_cnt)}) begin
                n_fail++;
                $display("FAIL random_%0d: Y=%0d hit=%0d miss=%0d idx=%0d cnt=%0d want %0d %0d %0d %0d %0d",
                         k, Y, hit, miss, rule_idx, trans_cnt, m_y, m_hit, m_miss, m_idx, m_cnt);
            end
        end
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        cnt_clr = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_mask_priority();
        test_write_race();
        test_counter();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
